// File: rtl/rename_freelist.sv
`default_nettype none
// ==== rename_freelist : GPR + T physical-tag free lists with speculative/commit heads. Rev 1.0 ====
// ==== Define FREELIST_ERR_EN to build the sticky fl_err checker; otherwise fl_err is tied 0. ====
module rename_freelist #(
    parameter int PRW = 5,
    parameter int TRW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         alloc_req,
    input  logic               t_alloc_req,
    output logic               alloc_gnt,
    output logic [2*PRW-1:0]   alloc_preg,
    output logic [TRW-1:0]     t_alloc_preg,
    input  logic [1:0]         rel_en,
    input  logic [2*PRW-1:0]   rel_preg,
    input  logic               t_rel_en,
    input  logic [TRW-1:0]     t_rel_preg,
    input  logic [1:0]         commit_cnt,
    input  logic               t_commit,
    input  logic               flush,
    output logic [4:0]         free_cnt,
    output logic [4:0]         t_free_cnt,
    output logic               fl_err
);

    logic [PRW-1:0] r_gpr [16];
    logic [4:0]     r_spec_head;
    logic [4:0]     r_commit_head;
    logic [4:0]     r_tail;
    logic [TRW-1:0] r_t_fl [16];
    logic [4:0]     r_t_spec_head;
    logic [4:0]     r_t_commit_head;
    logic [4:0]     r_t_tail;

    logic [1:0]     w_n_alloc;
    logic [1:0]     w_n_rel;
    logic [4:0]     w_used;
    logic [4:0]     w_t_used;
    logic           w_rel_ok;
    logic           w_t_rel_ok;
    logic           w_commit_ok;
    logic           w_t_commit_ok;
    logic [1:0]     w_commit_eff;
    logic           w_t_commit_eff;
    logic [3:0]     w_wr_idx1;

    assign w_n_alloc  = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
    assign w_n_rel    = {1'b0, rel_en[0]} + {1'b0, rel_en[1]};
    assign free_cnt   = r_tail - r_spec_head;
    assign t_free_cnt = r_t_tail - r_t_spec_head;

    assign alloc_gnt = !flush && ({3'b000, w_n_alloc} <= free_cnt)
                       && (!t_alloc_req || (t_free_cnt != 5'd0));

    // Slot 1 takes the second head entry only when slot 0 is also requesting.
    assign alloc_preg[PRW-1:0]       = r_gpr[r_spec_head[3:0]];
    assign alloc_preg[2*PRW-1:PRW]   = r_gpr[r_spec_head[3:0] + {3'b000, alloc_req[0]}];
    assign t_alloc_preg              = r_t_fl[r_t_spec_head[3:0]];

    assign w_rel_ok       = (free_cnt + {3'b000, w_n_rel}) <= 5'd16;
    assign w_t_rel_ok     = !t_rel_en || (t_free_cnt != 5'd16);
    assign w_used         = r_spec_head - r_commit_head;
    assign w_t_used       = r_t_spec_head - r_t_commit_head;
    assign w_commit_ok    = {3'b000, commit_cnt} <= w_used;
    assign w_t_commit_ok  = !t_commit || (w_t_used != 5'd0);
    assign w_commit_eff   = w_commit_ok ? commit_cnt : 2'd0;
    assign w_t_commit_eff = t_commit && w_t_commit_ok;
    assign w_wr_idx1      = r_tail[3:0] + {3'b000, rel_en[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_gpr[i] <= PRW'(16 + i);
            r_spec_head   <= 5'd0;
            r_commit_head <= 5'd0;
            r_tail        <= 5'd16;
        end else begin
            r_commit_head <= r_commit_head + {3'b000, w_commit_eff};
            if (flush)
                r_spec_head <= r_commit_head + {3'b000, w_commit_eff};
            else if (alloc_gnt)
                r_spec_head <= r_spec_head + {3'b000, w_n_alloc};
            if (w_rel_ok) begin
                if (rel_en[0]) r_gpr[r_tail[3:0]] <= rel_preg[PRW-1:0];
                if (rel_en[1]) r_gpr[w_wr_idx1]   <= rel_preg[2*PRW-1:PRW];
                r_tail <= r_tail + {3'b000, w_n_rel};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_t_fl[i] <= (i < 15) ? TRW'(i + 1) : '0;
            r_t_spec_head   <= 5'd0;
            r_t_commit_head <= 5'd0;
            r_t_tail        <= 5'd15;
        end else begin
            r_t_commit_head <= r_t_commit_head + {4'b0000, w_t_commit_eff};
            if (flush)
                r_t_spec_head <= r_t_commit_head + {4'b0000, w_t_commit_eff};
            else if (alloc_gnt && t_alloc_req)
                r_t_spec_head <= r_t_spec_head + 5'd1;
            if (t_rel_en && w_t_rel_ok) begin
                r_t_fl[r_t_tail[3:0]] <= t_rel_preg;
                r_t_tail <= r_t_tail + 5'd1;
            end
        end
    end

`ifdef FREELIST_ERR_EN
    logic r_fl_err;
    logic w_dup;
    logic w_ovf;
    logic w_ocm;

    assign w_ovf = ((|rel_en) && !w_rel_ok) || !w_t_rel_ok;
    assign w_ocm = !w_commit_ok || !w_t_commit_ok;

    // An entry is "in the list" when its offset from spec_head is below the free count.
    always_comb begin
        w_dup = rel_en[0] && rel_en[1] && (rel_preg[PRW-1:0] == rel_preg[2*PRW-1:PRW]);
        for (int i = 0; i < 16; i++) begin
            if ({1'b0, 4'(i) - r_spec_head[3:0]} < free_cnt) begin
                if (rel_en[0] && (r_gpr[i] == rel_preg[PRW-1:0]))     w_dup = 1'b1;
                if (rel_en[1] && (r_gpr[i] == rel_preg[2*PRW-1:PRW])) w_dup = 1'b1;
            end
            if (({1'b0, 4'(i) - r_t_spec_head[3:0]} < t_free_cnt)
                && t_rel_en && (r_t_fl[i] == t_rel_preg))
                w_dup = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fl_err <= 1'b0;
        else        r_fl_err <= r_fl_err | w_ovf | w_ocm | w_dup;
    end

    assign fl_err = r_fl_err;
`else
    assign fl_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rename_freelist.sv
`default_nettype none
// tb_rename_freelist: directed + random stimulus checked against a queue-based free-list model.
module tb_rename_freelist;
    localparam int PRW = 5;
    localparam int TRW = 4;
`ifdef FREELIST_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       alloc_req;
    logic             t_alloc_req;
    logic             alloc_gnt;
    logic [2*PRW-1:0] alloc_preg;
    logic [TRW-1:0]   t_alloc_preg;
    logic [1:0]       rel_en;
    logic [2*PRW-1:0] rel_preg;
    logic             t_rel_en;
    logic [TRW-1:0]   t_rel_preg;
    logic [1:0]       commit_cnt;
    logic             t_commit;
    logic             flush;
    logic [4:0]       free_cnt;
    logic [4:0]       t_free_cnt;
    logic             fl_err;

    rename_freelist #(.PRW(PRW), .TRW(TRW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .t_alloc_req(t_alloc_req),
        .alloc_gnt(alloc_gnt), .alloc_preg(alloc_preg), .t_alloc_preg(t_alloc_preg),
        .rel_en(rel_en), .rel_preg(rel_preg), .t_rel_en(t_rel_en), .t_rel_preg(t_rel_preg),
        .commit_cnt(commit_cnt), .t_commit(t_commit), .flush(flush),
        .free_cnt(free_cnt), .t_free_cnt(t_free_cnt), .fl_err(fl_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    // Model: free tags in allocation order, allocated-uncommitted tags, committed tags awaiting release.
    int gfree[$], ginfl[$], gret[$];
    int tfree[$], tinfl[$], tret[$];
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        alloc_req = 2'b00; t_alloc_req = 1'b0; rel_en = 2'b00; rel_preg = '0;
        t_rel_en = 1'b0; t_rel_preg = '0; commit_cnt = 2'd0; t_commit = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        #2 rst_n = 1'b0;
        gfree.delete(); ginfl.delete(); gret.delete();
        tfree.delete(); tinfl.delete(); tret.delete();
        for (int i = 0; i < 16; i++) gfree.push_back(16 + i);
        for (int i = 1; i < 16; i++) tfree.push_back(i);
        m_err = 1'b0;
        #4;
        chk("rst_free_cnt", 32'(free_cnt), 32'd16);
        chk("rst_t_free_cnt", 32'(t_free_cnt), 32'd15);
        chk("rst_fl_err", 32'(fl_err), 32'd0);
        chk("rst_gnt", 32'(alloc_gnt), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Checks outputs against the model at the falling edge, then advances the model one cycle.
    task automatic step();
        int na, nr, k;
        bit gnt, rel_ok, t_rel_ok, dup;
        int rels[$];
        @(negedge clk);
        na  = int'(alloc_req[0]) + int'(alloc_req[1]);
        gnt = !flush && (na <= gfree.size()) && (!t_alloc_req || tfree.size() >= 1);
        chk("alloc_gnt", 32'(alloc_gnt), 32'(gnt));
        chk("free_cnt", 32'(free_cnt), 32'(gfree.size()));
        chk("t_free_cnt", 32'(t_free_cnt), 32'(tfree.size()));
        chk("fl_err", 32'(fl_err), 32'(m_err));
        if (gnt) begin
            k = 0;
            if (alloc_req[0]) begin
                chk("preg_slot0", 32'(alloc_preg[PRW-1:0]), 32'(gfree[0]));
                k = 1;
            end
            if (alloc_req[1]) chk("preg_slot1", 32'(alloc_preg[2*PRW-1:PRW]), 32'(gfree[k]));
            if (t_alloc_req)  chk("t_preg", 32'(t_alloc_preg), 32'(tfree[0]));
        end
        if (rel_en[0]) rels.push_back(int'(rel_preg[PRW-1:0]));
        if (rel_en[1]) rels.push_back(int'(rel_preg[2*PRW-1:PRW]));
        nr       = rels.size();
        rel_ok   = (gfree.size() + nr) <= 16;
        t_rel_ok = !t_rel_en || (tfree.size() < 16);
        dup      = (nr == 2) && (rels[0] == rels[1]);
        foreach (rels[j]) foreach (gfree[m]) if (gfree[m] == rels[j]) dup = 1'b1;
        if (t_rel_en) foreach (tfree[m]) if (tfree[m] == int'(t_rel_preg)) dup = 1'b1;
        if (ERR_EN && ((nr > 0 && !rel_ok) || !t_rel_ok || dup)) m_err = 1'b1;
        if (int'(commit_cnt) > ginfl.size()) begin
            if (ERR_EN) m_err = 1'b1;
        end else begin
            repeat (int'(commit_cnt)) gret.push_back(ginfl.pop_front());
        end
        if (t_commit) begin
            if (tinfl.size() == 0) begin
                if (ERR_EN) m_err = 1'b1;
            end else begin
                tret.push_back(tinfl.pop_front());
            end
        end
        if (gnt) begin
            repeat (na) ginfl.push_back(gfree.pop_front());
            if (t_alloc_req) tinfl.push_back(tfree.pop_front());
        end
        if (flush) begin
            while (ginfl.size() > 0) gfree.push_front(ginfl.pop_back());
            while (tinfl.size() > 0) tfree.push_front(tinfl.pop_back());
        end
        if (rel_ok) foreach (rels[j]) gfree.push_back(rels[j]);
        if (t_rel_en && t_rel_ok) tfree.push_back(int'(t_rel_preg));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, r, slot;
        do_reset();

        // Dual allocation from reset
        alloc_req = 2'b11;
        #1 chk("d032_gnt", 32'(alloc_gnt), 32'd1);
        chk("d032_preg", 32'(alloc_preg), 32'({5'd17, 5'd16}));
        step();
        clear_inputs();
        #1 chk("d032_free", 32'(free_cnt), 32'd14);
        step();

        // Slot 1 alone takes the head entry
        do_reset();
        alloc_req = 2'b10;
        #1 chk("d033_slot1", 32'(alloc_preg[2*PRW-1:PRW]), 32'd16);
        step();
        clear_inputs();
        #1 chk("d033_free", 32'(free_cnt), 32'd15);

        // Exhaust the list, then refused alloc with same-cycle release
        do_reset();
        alloc_req = 2'b11;
        repeat (8) step();
        alloc_req = 2'b01; rel_en = 2'b01; rel_preg = {5'd0, 5'd3};
        #1 chk("d034_gnt", 32'(alloc_gnt), 32'd0);
        step();
        rel_en = 2'b00;
        #1 chk("d034_free", 32'(free_cnt), 32'd1);
        chk("d034_tag", 32'(alloc_preg[PRW-1:0]), 32'd3);
        step();

        // Allocate 4, commit 2, flush
        do_reset();
        alloc_req = 2'b11;
        repeat (2) step();
        alloc_req = 2'b00; commit_cnt = 2'd2;
        step();
        commit_cnt = 2'd0; flush = 1'b1;
        step();
        flush = 1'b0;
        #1 chk("d035_free", 32'(free_cnt), 32'd14);
        alloc_req = 2'b01;
        #1 chk("d035_tag", 32'(alloc_preg[PRW-1:0]), 32'd18);
        step();

        // Drain the T list
        do_reset();
        t_alloc_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1 chk("d036_ttag", 32'(t_alloc_preg), 32'(i + 1));
            step();
        end
        #1 chk("d036_gnt", 32'(alloc_gnt), 32'd0);
        step();

        // Release into a full list
        do_reset();
        rel_en = 2'b01; rel_preg = {5'd0, 5'd5};
        step();
        clear_inputs();
        #1 chk("d037_err", 32'(fl_err), 32'(ERR_EN));
        chk("d037_free", 32'(free_cnt), 32'd16);
        step();

        // Randomized traffic with tag conservation, occasional flush/over-commit/reset
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 700 == 699) do_reset();
            clear_inputs();
            flush       = ($urandom_range(0, 24) == 0);
            alloc_req   = 2'($urandom);
            t_alloc_req = ($urandom_range(0, 2) == 0);
            c = $urandom_range(0, 2);
            if (c > ginfl.size()) c = ginfl.size();
            if ($urandom_range(0, 299) == 0 && ginfl.size() < 2) c = ginfl.size() + 1;
            commit_cnt = 2'(c);
            t_commit   = (tinfl.size() > 0) && ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 2);
            if (r > gret.size()) r = gret.size();
            if (r == 2) begin
                rel_en = 2'b11;
                rel_preg[PRW-1:0]     = PRW'(gret.pop_front());
                rel_preg[2*PRW-1:PRW] = PRW'(gret.pop_front());
            end else if (r == 1) begin
                slot = $urandom_range(0, 1);
                rel_en[slot] = 1'b1;
                rel_preg[slot*PRW +: PRW] = PRW'(gret.pop_front());
            end
            if (tret.size() > 0 && $urandom_range(0, 1) == 1) begin
                t_rel_en   = 1'b1;
                t_rel_preg = TRW'(tret.pop_front());
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
